// File: rtl/fetch_issue_unit.sv
// ---------------------------------------------------------------------------
// fetch_issue_unit
//   Pipeline front end. Reads 16-bit words from instruction memory at pc and
//   issues registered {instr, imm, pc} bundles to decode. A two-word LDM
//   (opcode 3'b001) is folded into one bundle. Pending interrupts are injected
//   as a NOP bundle flagged with o_int, and only at instruction boundaries.
//   Redirects (i_flush) and decode back-pressure (i_stall) come from later
//   stages.
//
// Handshake: o_valid marks a bundle. i_stall acts as "decode not ready": while
//   it is high every output, pc and the FSM hold. A bundle is consumed on the
//   first rising edge where o_valid=1 and i_stall=0. i_flush overrides the
//   stall and kills the current bundle.
//
// Ports
//   i_clk, i_rst_n    clock, asynchronous active-low reset
//   o_imem_addr       instruction-memory address (= pc, combinational)
//   i_imem_data       instruction-memory read data, same cycle
//   i_stall           hold everything
//   i_flush           squash in-flight work and load i_flush_pc
//   i_flush_pc        redirect target
//   i_interrupt       interrupt request, level sampled every cycle
//   o_valid, o_int    bundle valid / bundle is an interrupt entry
//   o_instr, o_imm    instruction word / LDM immediate (else 0)
//   o_pc              address of the first word of the issued instruction
//   o_state           debug view of the FSM (0 = S_FETCH, 1 = S_IMM)
// ---------------------------------------------------------------------------
module fetch_issue_unit #(
  parameter int                 PC_W         = 16,
  parameter logic [PC_W-1:0]    RESET_VECTOR = 'h0000,
  parameter logic [PC_W-1:0]    INT_VECTOR   = 'h0002
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  output logic [PC_W-1:0] o_imem_addr,
  input  logic [15:0]     i_imem_data,
  input  logic            i_stall,
  input  logic            i_flush,
  input  logic [PC_W-1:0] i_flush_pc,
  input  logic            i_interrupt,
  output logic            o_valid,
  output logic [15:0]     o_instr,
  output logic [15:0]     o_imm,
  output logic [PC_W-1:0] o_pc,
  output logic            o_int,
  output logic            o_state
);

  typedef enum logic {S_FETCH = 1'b0, S_IMM = 1'b1} state_t;

  localparam logic [15:0]     NOP_WORD = 16'hA000;
  localparam logic [2:0]      OP_LDM   = 3'b001;
  localparam logic [PC_W-1:0] PC_ONE   = 1;

  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [15:0]     hold_q, hold_d;
  logic            int_pend_q, int_pend_d;
  logic            valid_d, int_d;
  logic [15:0]     instr_d, imm_d;
  logic [PC_W-1:0] opc_d;

  assign o_imem_addr = pc_q;
  assign o_state     = state_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= S_FETCH;
      pc_q       <= RESET_VECTOR;
      hold_q     <= '0;
      int_pend_q <= 1'b0;
      o_valid    <= 1'b0;
      o_int      <= 1'b0;
      o_instr    <= '0;
      o_imm      <= '0;
      o_pc       <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      hold_q     <= hold_d;
      int_pend_q <= int_pend_d;
      o_valid    <= valid_d;
      o_int      <= int_d;
      o_instr    <= instr_d;
      o_imm      <= imm_d;
      o_pc       <= opc_d;
    end
  end

  // Priority: flush > stall > interrupt > normal issue.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    hold_d     = hold_q;
    valid_d    = o_valid;
    int_d      = o_int;
    instr_d    = o_instr;
    imm_d      = o_imm;
    opc_d      = o_pc;
    // The request is latched even while stalled or flushed so it is never lost.
    int_pend_d = int_pend_q | i_interrupt;

    if (i_flush) begin
      // A half-fetched LDM is simply abandoned by returning to S_FETCH.
      pc_d    = i_flush_pc;
      state_d = S_FETCH;
      valid_d = 1'b0;
      int_d   = 1'b0;
    end else if (!i_stall) begin
      unique case (state_q)
        S_FETCH: begin
          if (int_pend_q) begin
            // The word at pc is not consumed; o_pc is the return address.
            valid_d    = 1'b1;
            int_d      = 1'b1;
            instr_d    = NOP_WORD;
            imm_d      = '0;
            opc_d      = pc_q;
            pc_d       = INT_VECTOR;
            int_pend_d = i_interrupt;
          end else if (i_imem_data[15:13] == OP_LDM) begin
            hold_d  = i_imem_data;
            opc_d   = pc_q;
            pc_d    = pc_q + PC_ONE;
            valid_d = 1'b0;
            int_d   = 1'b0;
            state_d = S_IMM;
          end else begin
            valid_d = 1'b1;
            int_d   = 1'b0;
            instr_d = i_imem_data;
            imm_d   = '0;
            opc_d   = pc_q;
            pc_d    = pc_q + PC_ONE;
          end
        end
        S_IMM: begin
          // o_pc already holds the first-word address from the S_FETCH cycle.
          valid_d = 1'b1;
          int_d   = 1'b0;
          instr_d = hold_q;
          imm_d   = i_imem_data;
          pc_d    = pc_q + PC_ONE;
          state_d = S_FETCH;
        end
        default: state_d = S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_issue_unit.sv
module tb_fetch_issue_unit;

  localparam int W = 66; // {valid, int, instr, imm, pc, addr}

  logic        i_clk;
  logic        i_rst_n;
  logic [15:0] o_imem_addr;
  logic [15:0] i_imem_data;
  logic        i_stall, i_flush, i_interrupt;
  logic [15:0] i_flush_pc;
  logic        o_valid, o_int, o_state;
  logic [15:0] o_instr, o_imm, o_pc;

  logic [15:0] mem [0:65535];
  assign i_imem_data = mem[o_imem_addr];

  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic        st;
    logic        fl;
    logic [15:0] fpc;
    logic        intr;
    logic        ev;
    logic        ei;
    logic [15:0] ein;
    logic [15:0] eim;
    logic [15:0] epc;
    logic [15:0] ea;
  } vec_t;

  vec_t vecs [24];

  fetch_issue_unit dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .o_imem_addr (o_imem_addr),
    .i_imem_data (i_imem_data),
    .i_stall     (i_stall),
    .i_flush     (i_flush),
    .i_flush_pc  (i_flush_pc),
    .i_interrupt (i_interrupt),
    .o_valid     (o_valid),
    .o_instr     (o_instr),
    .o_imm       (o_imm),
    .o_pc        (o_pc),
    .o_int       (o_int),
    .o_state     (o_state)
  );

  // clock / reset
  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  function automatic vec_t v(logic st, logic fl, logic [15:0] fpc, logic intr,
                             logic ev, logic ei, logic [15:0] ein, logic [15:0] eim,
                             logic [15:0] epc, logic [15:0] ea);
    vec_t r;
    r = '{st, fl, fpc, intr, ev, ei, ein, eim, epc, ea};
    return r;
  endfunction

  // scoreboard: pop one expectation and compare. When the expected bundle is
  // invalid (and full=0) only valid, int and the fetch address are compared.
  task automatic check_out(input string name, input logic full);
    logic [W-1:0] e, a;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: scoreboard queue empty", name);
      return;
    end
    e = exp_q.pop_front();
    a = {o_valid, o_int, o_instr, o_imm, o_pc, o_imem_addr};
    if (!full && !e[65]) begin
      e[63:16] = '0;
      a[63:16] = '0;
    end
    n_checks++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got v=%0b int=%0b instr=%h imm=%h pc=%h addr=%h, expected v=%0b int=%0b instr=%h imm=%h pc=%h addr=%h",
               name, a[65], a[64], a[63:48], a[47:32], a[31:16], a[15:0],
               e[65], e[64], e[63:48], e[47:32], e[31:16], e[15:0]);
    end
  endtask

  // driver: inputs are applied at the falling edge, outputs checked 1 ns after
  // the following rising edge, then we return at the next falling edge.
  task automatic step(input string name, input vec_t t);
    i_stall     = t.st;
    i_flush     = t.fl;
    i_flush_pc  = t.fpc;
    i_interrupt = t.intr;
    exp_q.push_back({t.ev, t.ei, t.ein, t.eim, t.epc, t.ea});
    @(posedge i_clk);
    #1;
    check_out(name, 1'b0);
    @(negedge i_clk);
  endtask

  initial begin
    // memory: random non-LDM filler, then the words the test relies on
    for (int i = 0; i < 65536; i++) begin
      logic [2:0] op;
      op = 3'($urandom_range(2, 7));
      mem[i] = {op, 13'($urandom_range(0, 8191))};
    end
    mem['h0000] = 16'h6000;
    mem['h0001] = 16'h8000;
    mem['h0002] = 16'h4002;
    mem['h0003] = 16'h4003;
    mem['h0004] = 16'h2000;
    mem['h0005] = 16'h1234;
    mem['h0040] = 16'hC040;
    mem['h0041] = 16'h2ABC;
    mem['h0042] = 16'h5555;
    mem['h0080] = 16'hE080;
    mem['hFFFF] = 16'h8000;

    //               st fl fpc       in ev ei instr     imm       pc        addr
    vecs[0]  = v(0, 0, 16'h0000, 0, 1, 0, 16'h6000, 16'h0000, 16'h0000, 16'h0001);
    vecs[1]  = v(0, 0, 16'h0000, 0, 1, 0, 16'h8000, 16'h0000, 16'h0001, 16'h0002);
    vecs[2]  = v(0, 0, 16'h0000, 0, 1, 0, 16'h4002, 16'h0000, 16'h0002, 16'h0003);
    vecs[3]  = v(0, 0, 16'h0000, 0, 1, 0, 16'h4003, 16'h0000, 16'h0003, 16'h0004);
    vecs[4]  = v(0, 0, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0005);
    vecs[5]  = v(0, 0, 16'h0000, 1, 1, 0, 16'h2000, 16'h1234, 16'h0004, 16'h0006);
    vecs[6]  = v(0, 0, 16'h0000, 0, 1, 1, 16'hA000, 16'h0000, 16'h0006, 16'h0002);
    vecs[7]  = v(0, 0, 16'h0000, 0, 1, 0, 16'h4002, 16'h0000, 16'h0002, 16'h0003);
    vecs[8]  = v(1, 0, 16'h0000, 0, 1, 0, 16'h4002, 16'h0000, 16'h0002, 16'h0003);
    vecs[9]  = v(1, 0, 16'h0000, 0, 1, 0, 16'h4002, 16'h0000, 16'h0002, 16'h0003);
    vecs[10] = v(1, 0, 16'h0000, 0, 1, 0, 16'h4002, 16'h0000, 16'h0002, 16'h0003);
    vecs[11] = v(1, 1, 16'h0040, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0040);
    vecs[12] = v(0, 0, 16'h0000, 0, 1, 0, 16'hC040, 16'h0000, 16'h0040, 16'h0041);
    vecs[13] = v(0, 0, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0042);
    vecs[14] = v(0, 1, 16'h0080, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0080);
    vecs[15] = v(0, 0, 16'h0000, 0, 1, 0, 16'hE080, 16'h0000, 16'h0080, 16'h0081);
    vecs[16] = v(1, 0, 16'h0000, 1, 1, 0, 16'hE080, 16'h0000, 16'h0080, 16'h0081);
    vecs[17] = v(0, 0, 16'h0000, 0, 1, 1, 16'hA000, 16'h0000, 16'h0081, 16'h0002);
    vecs[18] = v(0, 1, 16'hFFFF, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'hFFFF);
    vecs[19] = v(0, 0, 16'h0000, 0, 1, 0, 16'h8000, 16'h0000, 16'hFFFF, 16'h0000);
    vecs[20] = v(0, 0, 16'h0000, 0, 1, 0, 16'h6000, 16'h0000, 16'h0000, 16'h0001);
    vecs[21] = v(0, 1, 16'h0010, 1, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0010);
    vecs[22] = v(0, 0, 16'h0000, 0, 1, 1, 16'hA000, 16'h0000, 16'h0010, 16'h0002);
    vecs[23] = v(0, 0, 16'h0000, 0, 1, 0, 16'h4002, 16'h0000, 16'h0002, 16'h0003);

    i_stall     = 1'b0;
    i_flush     = 1'b0;
    i_flush_pc  = '0;
    i_interrupt = 1'b0;
    i_rst_n     = 1'b0;

    // reset state
    repeat (2) @(posedge i_clk);
    #1;
    exp_q.push_back('0);
    check_out("reset_state", 1'b1);
    @(negedge i_clk);
    i_rst_n = 1'b1;

    // table-driven main sequence
    for (int k = 0; k < 24; k++) begin
      step($sformatf("vec%0d", k), vecs[k]);
    end

    // async reset in the middle of a cycle clears outputs immediately
    #2 i_rst_n = 1'b0;
    #1;
    exp_q.push_back('0);
    check_out("async_reset", 1'b1);
    @(negedge i_clk);
    i_rst_n = 1'b1;

    // LDM split across the address wrap
    mem['hFFFF] = 16'h2007;
    step("wrap_flush", v(0, 1, 16'hFFFF, 0, 0, 0, 16'h0, 16'h0, 16'h0, 16'hFFFF));
    step("wrap_bubble", v(0, 0, 16'h0, 0, 0, 0, 16'h0, 16'h0, 16'h0, 16'h0000));
    step("wrap_ldm", v(0, 0, 16'h0, 0, 1, 0, 16'h2007, 16'h6000, 16'hFFFF, 16'h0001));

    // reset in the middle of an LDM drops the held word
    step("mid_flush", v(0, 1, 16'h0004, 0, 0, 0, 16'h0, 16'h0, 16'h0, 16'h0004));
    step("mid_bubble", v(0, 0, 16'h0, 0, 0, 0, 16'h0, 16'h0, 16'h0, 16'h0005));
    #1 i_rst_n = 1'b0;
    #1;
    exp_q.push_back('0);
    check_out("mid_ldm_reset", 1'b1);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    step("after_reset", v(0, 0, 16'h0, 0, 1, 0, 16'h6000, 16'h0000, 16'h0000, 16'h0001));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // hard time limit so the run always ends
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete, got running, expected done");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "timeout");
  end

endmodule
